// File: rtl/smachine_pc_tracer.sv
// PC trace capture for the S-Machine: pushes each new enabled-cycle PC into a FIFO, stops on halt.
// Optional PC_TRACE_TIMESTAMP_EN prepends an 8-bit enabled-cycle timestamp to every entry.
module smachine_pc_tracer #(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HALT_CYCLES = 4,
`ifdef PC_TRACE_TIMESTAMP_EN
    localparam int unsigned ENTRY_W    = PC_W + 8
`else
    localparam int unsigned ENTRY_W    = PC_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [PC_W-1:0]          count,
    input  logic                     arm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ENTRY_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    output logic                     halted,
    output logic                     capturing
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(HALT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StCapture, StHalted} state_e;

    state_e              state_q, state_d;
    logic                arm_q;
    logic [PC_W-1:0]     last_pc_q, last_pc_d;
    logic                first_q, first_d;
    logic [SW-1:0]       stuck_q, stuck_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         fill_q, fill_d;
    logic                overflow_q, overflow_d;
    logic                halted_q, halted_d;
    logic [ENTRY_W-1:0]  mem_q [DEPTH];

    logic                arm_rise, push_req, push, pop, full;
    logic [ENTRY_W-1:0]  entry;

`ifdef PC_TRACE_TIMESTAMP_EN
    logic [7:0] ts_q, ts_d;

    always_comb begin
        ts_d = ts_q;
        if (arm_rise) begin
            ts_d = '0;
        end else if (enable) begin
            ts_d = ts_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign entry = {ts_q, count};
`else
    assign entry = count;
`endif

    // Capture FSM: arm rising edge restarts from any state.
    always_comb begin
        arm_rise  = arm & ~arm_q;
        state_d   = state_q;
        last_pc_d = last_pc_q;
        first_d   = first_q;
        stuck_d   = stuck_q;
        halted_d  = halted_q;
        push_req  = 1'b0;
        if (arm_rise) begin
            state_d  = StCapture;
            first_d  = 1'b1;
            stuck_d  = '0;
            halted_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StCapture: begin
                    if (!arm) begin
                        state_d = StIdle;
                    end else if (enable) begin
                        last_pc_d = count;
                        first_d   = 1'b0;
                        if (first_q || count != last_pc_q) begin
                            push_req = 1'b1;
                            stuck_d  = '0;
                        end else if (stuck_q == SW'(HALT_CYCLES - 1)) begin
                            stuck_d  = SW'(HALT_CYCLES);
                            state_d  = StHalted;
                            halted_d = 1'b1;
                        end else begin
                            stuck_d = stuck_q + SW'(1);
                        end
                    end
                end
                StHalted: begin
                    if (!arm) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FIFO bookkeeping; a flush overrides any concurrent pop.
    always_comb begin
        full       = (fill_q == (AW + 1)'(DEPTH));
        pop        = out_valid & out_ready & ~arm_rise;
        push       = push_req & (~full | pop);
        overflow_d = overflow_q | (push_req & full & ~pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        fill_d     = fill_q + (AW + 1)'(push) - (AW + 1)'(pop);
        if (arm_rise) begin
            overflow_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fill_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            arm_q      <= 1'b0;
            last_pc_q  <= '0;
            first_q    <= 1'b0;
            stuck_q    <= '0;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm;
            last_pc_q  <= last_pc_d;
            first_q    <= first_d;
            stuck_q    <= stuck_d;
            halted_q   <= halted_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    always_comb begin
        out_valid = (fill_q != '0);
        out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
        fill      = fill_q;
        overflow  = overflow_q;
        halted    = halted_q;
        capturing = (state_q == StCapture);
    end

endmodule

// File: tb/tb_smachine_pc_tracer.sv
// Bench for smachine_pc_tracer: queue-based reference model checked every cycle plus directed cases.
module tb_smachine_pc_tracer;

    localparam int PC_W        = 8;
    localparam int DEPTH       = 16;
    localparam int HALT_CYCLES = 4;
`ifdef PC_TRACE_TIMESTAMP_EN
    localparam int EW = PC_W + 8;
`else
    localparam int EW = PC_W;
`endif

    typedef logic [EW-1:0] entry_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  enable = 1'b0;
    logic [PC_W-1:0]       count = '0;
    logic                  arm = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [EW-1:0]         out_data;
    logic [$clog2(DEPTH):0] fill;
    logic                  overflow, halted, capturing;

    int n_cmp = 0;
    int n_bad = 0;

    smachine_pc_tracer #(
        .PC_W(PC_W), .DEPTH(DEPTH), .HALT_CYCLES(HALT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .count(count), .arm(arm),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fill(fill), .overflow(overflow), .halted(halted), .capturing(capturing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 capturing, 2 halted; FIFO is a plain queue.
    entry_t     mq[$];
    int         m_mode = 0;
    bit         m_prev_arm = 0;
    bit         m_first = 0;
    logic [PC_W-1:0] m_last = '0;
    int         m_stuck = 0;
    bit         m_ovf = 0;
    bit         m_halted = 0;
`ifdef PC_TRACE_TIMESTAMP_EN
    logic [7:0] m_ts = '0;
`endif

    always @(posedge clk or negedge rst_n) begin : model
        bit     rise, do_pop, do_push;
        entry_t e;
        if (!rst_n) begin
            mq.delete();
            m_mode = 0; m_prev_arm = 0; m_first = 0; m_last = '0;
            m_stuck = 0; m_ovf = 0; m_halted = 0;
`ifdef PC_TRACE_TIMESTAMP_EN
            m_ts = '0;
`endif
        end else begin
`ifdef PC_TRACE_TIMESTAMP_EN
            e = {m_ts, count};
`else
            e = count;
`endif
            rise = arm && !m_prev_arm;
            do_push = 0;
            if (rise) begin
                m_mode = 1; mq.delete(); m_ovf = 0; m_halted = 0; m_stuck = 0; m_first = 1;
`ifdef PC_TRACE_TIMESTAMP_EN
                m_ts = '0;
`endif
            end else begin
                do_pop = (mq.size() != 0) && out_ready;
                if (m_mode == 1) begin
                    if (!arm) begin
                        m_mode = 0;
                    end else if (enable) begin
                        if (m_first || count != m_last) begin
                            do_push = 1;
                            m_stuck = 0;
                        end else begin
                            m_stuck++;
                            if (m_stuck == HALT_CYCLES) begin
                                m_mode = 2;
                                m_halted = 1;
                            end
                        end
                        m_last = count;
                        m_first = 0;
                    end
                end else if (m_mode == 2 && !arm) begin
                    m_mode = 0;
                end
                if (do_push && mq.size() == DEPTH && !do_pop) begin
                    m_ovf = 1;
                    do_push = 0;
                end
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(e);
`ifdef PC_TRACE_TIMESTAMP_EN
                if (enable) m_ts = m_ts + 8'd1;
`endif
            end
            m_prev_arm = arm;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("fill", 32'(fill), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("capturing", 32'(capturing), 32'(m_mode == 1));
        if (mq.size() != 0) chk("data", 32'(out_data), 32'(mq[0]));
        if (!rst_n) chk("data_rst", 32'(out_data), 32'd0);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rearm();
        arm = 1'b0;
        cyc();
        arm = 1'b1;
        cyc();
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_fill"}, 32'(fill), 32'd0);
        chk({nm, "_ovf"}, 32'(overflow), 32'd0);
        chk({nm, "_halted"}, 32'(halted), 32'd0);
        chk({nm, "_capt"}, 32'(capturing), 32'd0);
        chk({nm, "_data"}, 32'(out_data), 32'd0);
    endtask

    logic [PC_W-1:0] wrap_vals [3];
    logic [PC_W-1:0] got[$];
    logic [EW-1:0]   prev_data;
    bit              prev_held;

    initial begin
        #3;
        chk_reset_outs("reset");
        cyc(2);
        rst_n = 1'b1;
        cyc();

        // Reset mid-capture, asserted between edges.
        arm = 1'b1;
        cyc();
        enable = 1'b1;
        for (int i = 3; i < 6; i++) begin
            count = PC_W'(i);
            cyc();
        end
        chk("pre_rst_fill", 32'(fill), 32'd3);
        #2 rst_n = 1'b0;
        arm = 1'b0;
        enable = 1'b0;
        #1;
        chk_reset_outs("async_rst");
        cyc();
        rst_n = 1'b1;
        cyc();

        // Linear program with the consumer stalled, then drained.
        arm = 1'b1;
        cyc();
        chk("lin_capturing", 32'(capturing), 32'd1);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            count = PC_W'(i);
            cyc();
        end
        enable = 1'b0;
        chk("lin_fill", 32'(fill), 32'd5);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("lin_valid", 32'(out_valid), 32'd1);
            chk("lin_pc", 32'(out_data[PC_W-1:0]), 32'(i));
`ifdef PC_TRACE_TIMESTAMP_EN
            chk("lin_ts", 32'(out_data[EW-1:PC_W]), 32'(i));
`endif
            cyc();
        end
        chk("lin_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Halt detection: 5,6,7 then 7 held.
        rearm();
        enable = 1'b1;
        count = 8'd5; cyc();
        count = 8'd6; cyc();
        count = 8'd7; cyc();
        cyc(3);
        chk("halt_not_yet", 32'(halted), 32'd0);
        cyc();
        chk("halt_set", 32'(halted), 32'd1);
        chk("halt_fill", 32'(fill), 32'd3);
        count = 8'd8;
        cyc(2);
        chk("halt_no_push", 32'(fill), 32'd3);
        enable = 1'b0;
        out_ready = 1'b1;
        for (int i = 5; i < 8; i++) begin
            chk("halt_pc", 32'(out_data[PC_W-1:0]), 32'(i));
            cyc();
        end
        out_ready = 1'b0;

        // Enable gating.
        rearm();
        count = 8'd1; cyc();
        count = 8'd2; cyc();
        enable = 1'b1; cyc();
        enable = 1'b0;
        chk("gate_fill", 32'(fill), 32'd1);
        chk("gate_pc", 32'(out_data[PC_W-1:0]), 32'd2);
        cyc(6);
        chk("gate_no_halt", 32'(halted), 32'd0);
        enable = 1'b1;
        cyc(3);
        chk("gate_stuck3", 32'(halted), 32'd0);
        cyc();
        chk("gate_halt", 32'(halted), 32'd1);
        enable = 1'b0;

        // Overflow, simultaneous push/pop when full, flush by re-arm.
        rearm();
        enable = 1'b1;
        for (int i = 0; i < 17; i++) begin
            count = PC_W'(8'h10 + i);
            cyc();
        end
        chk("ovf_fill", 32'(fill), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        count = 8'h40;
        out_ready = 1'b1;
        cyc();
        chk("ovf_pushpop_fill", 32'(fill), 32'd16);
        out_ready = 1'b0;
        enable = 1'b0;
        rearm();
        chk("ovf_flush_fill", 32'(fill), 32'd0);
        chk("ovf_flush_flag", 32'(overflow), 32'd0);

        // PC wrap with toggling backpressure.
        wrap_vals[0] = 8'hFE; wrap_vals[1] = 8'hFF; wrap_vals[2] = 8'h00;
        prev_held = 0;
        for (int k = 0; k < 16; k++) begin
            enable = (k < 3);
            if (k < 3) count = wrap_vals[k];
            out_ready = k[0];
            #1;
            if (prev_held) chk("bp_stable", 32'(out_data), 32'(prev_data));
            if (out_valid && out_ready) got.push_back(out_data[PC_W-1:0]);
            prev_held = out_valid && !out_ready;
            prev_data = out_data;
            cyc();
        end
        out_ready = 1'b0;
        enable = 1'b0;
        chk("wrap_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("wrap_pc", (got.size() > i) ? 32'(got[i]) : 32'hDEAD, 32'(wrap_vals[i]));
        end

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(99) < 3) arm = ~arm;
            enable = ($urandom_range(3) != 0);
            if ($urandom_range(2) != 0) count = PC_W'($urandom_range(7) + (k % 3 == 0 ? 250 : 0));
            out_ready = ($urandom_range(2) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/smachine_pc_tracer.md
# smachine_pc_tracer

Hardware trace capture for the S-Machine CPU. Samples the CPU program counter (`count`) on every enabled clock and pushes each new PC value into an internal FIFO. The FIFO is drained through a valid/ready read port. Also detects a halted CPU (PC stuck) and stops capture. Sits beside `SMachine` on the same `clk`/`enable` and provides the in-hardware observer of the PC that a bench otherwise checks by eye.

## Interface
Parameters:
- `PC_W`, 8, width of `count` and of the PC field of each entry
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `HALT_CYCLES`, 4, consecutive enabled cycles with an unchanged PC that declare a halt; ≥ 1

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  CPU enable; the tracer samples only when high
- `count`  in  PC_W  CPU program counter
- `arm`  in  1  level; high = capture requested
- `out_valid`  out  1  FIFO head is valid
- `out_ready`  in  1  consumer accepts the head
- `out_data`  out  ENTRY_W  FIFO head entry (see Configuration)
- `fill`  out  clog2(DEPTH)+1  number of entries held
- `overflow`  out  1  sticky; a push was dropped because the FIFO was full
- `halted`  out  1  halt detected
- `capturing`  out  1  FSM is in CAPTURE

## Operation
- FSM states are IDLE, CAPTURE and HALTED. Reset state is IDLE.
- Rising edge of `arm` (registered compare, from any state):
  - enters CAPTURE;
  - flushes the FIFO (`fill`=0);
  - clears `overflow`, `halted`, the stuck counter and the timestamp.
- `arm` low in CAPTURE or HALTED → IDLE. FIFO contents are retained and remain readable.
- CAPTURE push rule, on a cycle with `enable`=1:
  - Push `count` if this is the first enabled sample since arm, or if `count` ≠ last pushed PC.
  - Every enabled sample updates the last-PC register.
- Stuck counter:
  - Increments on each enabled cycle where `count` equals the last PC.
  - Resets to 0 when the PC changes.
  - When it reaches HALT_CYCLES: go to HALTED, set `halted`=1, stop pushing.
- HALTED: no pushes. Leaves only via `arm` low (→ IDLE) or a new `arm` rising edge.
- Cycles with `enable`=0 are ignored: no push, stuck counter holds.
- PC wrap-around (e.g. 0xFF→0x00) is a change and is pushed.
- Read side, in any state: an entry pops when `out_valid`&&`out_ready`. `out_data` holds steady while `out_valid`=1 and `out_ready`=0.
- Full FIFO (`fill`=DEPTH):
  - A push with no pop is dropped and sets `overflow`=1.
  - Push and pop in the same cycle: both are accepted, `fill` is unchanged, no overflow.
- Empty FIFO: `out_valid`=0 and `out_data` is don't-care. A pop request with `out_valid`=0 is ignored.
- `arm` rising edge in the same cycle as a pop: the flush wins and `fill`=0.

## Timing
- Reset values: `out_valid`=0, `fill`=0, `overflow`=0, `halted`=0, `capturing`=0, `out_data`=0. FIFO pointers are 0. Reset asserts asynchronously and releases synchronously to `clk`.
- `arm` edge sampled at edge N → `capturing`=1 after edge N. The first possible push is at edge N+1.
- Push latency: `count` sampled at edge N → entry visible (`out_valid`=1, `fill`+1) after edge N. No combinational fall-through from `count` to `out_data`.
- A pop at edge N: the next head appears on `out_data` after edge N.
- `halted` asserts after the edge on which the stuck counter reaches HALT_CYCLES.
- Full throughput: one push and one pop per cycle.

## Configuration
- `PC_TRACE_TIMESTAMP_EN` defined:
  - An 8-bit counter of enabled cycles since the last `arm` rising edge; it wraps 255→0.
  - Each entry is {timestamp, PC} and ENTRY_W = PC_W+8. The timestamp is in the upper bits.
  - The timestamp stored with an entry is the counter value on the cycle that PC was sampled. The first sample after arm has timestamp 0.
- Macro undefined: no counter; ENTRY_W = PC_W and `out_data` = PC only.

## Test plan
- Reset mid-capture: arm, push 3 PCs, assert `rst_n`=0 asynchronously → every output returns to its reset value immediately, with no clock edge.
- Linear program: arm, `enable`=1, `count` 0,1,2,3,4, `out_ready`=0 → `fill`=5. Then `out_ready`=1 → `out_data` reads 0,1,2,3,4 in order; `out_valid` drops after 5 pops. With timestamp enabled, entries are {0,0},{1,1},…,{4,4}.
- Halt: `count` goes 5,6,7 and then stays 7 for 4 enabled cycles with HALT_CYCLES=4 → FIFO holds 5,6,7 and `halted`=1. Later changes of `count` to 8 are not pushed.
- Enable gating: `count` changes 1→2 while `enable`=0, then `enable`=1 with `count`=2 → exactly one entry of 2 is pushed. The stuck counter does not advance during `enable`=0.
- Overflow and simultaneity: DEPTH=16, push 17 distinct PCs with no reads → `fill`=16 and `overflow`=1. Then a push and a pop in the same cycle → `fill` stays 16. A new `arm` rising edge → `fill`=0 and `overflow`=0.
- Wrap and backpressure: `count` 0xFE,0xFF,0x00 with `out_ready` toggling every cycle → three entries FE,FF,00 are delivered in order. `out_data` stays stable while `out_ready`=0.
